// File: rtl/keccak_absorb_ctrl_pkg.sv
// Shared SHAKE256 absorb constants and FSM encodings.
// Imported by the absorb controller.
package keccak_absorb_ctrl_pkg;

  localparam int KECCAK_RATE     = 1088;
  localparam int KECCAK_STATE    = 1600;
  localparam int KECCAK_CAPACITY = KECCAK_STATE - KECCAK_RATE;
  localparam int KECCAK_PERM_TO  = 255;
  localparam int KECCAK_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XOR  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACK  = 3'd4,
    ST_DONE = 3'd5
  } absorb_st_e;

  // Quiet states are the only ones that accept blocks and clears.
  function automatic logic is_quiet(input absorb_st_e st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/keccak_absorb_ctrl_edge.sv
// One-bit registered rising-edge detector.
// Used for the accumulator done level and the permutation done pulse.
module keccak_absorb_ctrl_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  // Next value of the history bit is simply the current input.
  always_comb begin
    prev_d = din;
  end

  // History register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// SHAKE256 absorb controller: XORs rate blocks into the Keccak
// state and sequences an external Keccak-f[1600] permutation.
module keccak_absorb_ctrl
  import keccak_absorb_ctrl_pkg::*;
#(
  parameter int RATE_BITS    = KECCAK_RATE,
  parameter int STATE_BITS   = KECCAK_STATE,
  parameter int PERM_TIMEOUT = KECCAK_PERM_TO,
  parameter int CNT_W        = KECCAK_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  state_clear,
  input  logic                  block_valid,
  input  logic [RATE_BITS-1:0]  block_in,
  input  logic                  last_block,
  output logic                  perm_start,
  output logic [STATE_BITS-1:0] perm_state_out,
  input  logic                  perm_done,
  input  logic [STATE_BITS-1:0] perm_state_in,
  output logic                  busy,
  output logic                  absorb_done,
  output logic                  squeeze_ready,
  output logic [STATE_BITS-1:0] state_out,
  output logic [CNT_W-1:0]      block_count,
  output logic                  timeout_err
);

  localparam int TW = $clog2(PERM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(PERM_TIMEOUT);

  absorb_st_e            st_d, st_q;
  logic [STATE_BITS-1:0] state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [TW-1:0]         tcnt_d, tcnt_q;
  logic                  sq_d, sq_q;
  logic                  terr_d, terr_q;
  logic                  last_d, last_q;
  logic                  blk_edge;
  logic                  done_pulse;

  keccak_absorb_ctrl_edge u_blk_edge (
    .clk   (clk),
    .reset (reset),
    .din   (block_valid),
    .rise  (blk_edge)
  );

  keccak_absorb_ctrl_edge u_done_edge (
    .clk   (clk),
    .reset (reset),
    .din   (perm_done),
    .rise  (done_pulse)
  );

  // Next-state and datapath updates for the absorb sequence.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    sq_d    = sq_q;
    terr_d  = terr_q;
    last_d  = last_q;
    unique case (st_q)
      ST_IDLE, ST_DONE: begin
        // Clear first so a coincident block starts a fresh message.
        if (state_clear) begin
          state_d = '0;
          cnt_d   = '0;
          sq_d    = 1'b0;
          terr_d  = 1'b0;
        end
        if (blk_edge) begin
          last_d = last_block;
          st_d   = ST_XOR;
        end
      end
      ST_XOR: begin
        state_d[RATE_BITS-1:0] = state_q[RATE_BITS-1:0] ^ block_in;
        st_d = ST_REQ;
      end
      ST_REQ: begin
        tcnt_d = '0;
        st_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (done_pulse) begin
          state_d = perm_state_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_q) begin
            sq_d = 1'b1;
          end
          st_d = ST_ACK;
        end else if (tcnt_q + TW'(1) == TO_LIM) begin
          terr_d = 1'b1;
          st_d   = ST_DONE;
        end
      end
      ST_ACK: begin
        st_d = ST_DONE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      sq_q    <= 1'b0;
      terr_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      sq_q    <= sq_d;
      terr_q  <= terr_d;
      last_q  <= last_d;
    end
  end

  assign perm_start     = (st_q == ST_REQ);
  assign absorb_done    = (st_q == ST_ACK);
  assign busy           = ~is_quiet(st_q);
  assign perm_state_out = state_q;
  assign state_out      = state_q;
  assign block_count    = cnt_q;
  assign squeeze_ready  = sq_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Directed testbench for keccak_absorb_ctrl with a simple
// permutation responder model.
module tb_keccak_absorb_ctrl;

  localparam int RB = 1088;
  localparam int SB = 1600;

  logic          clk = 1'b0;
  logic          reset;
  logic          state_clear;
  logic          block_valid;
  logic [RB-1:0] block_in;
  logic          last_block;
  logic          perm_start;
  logic [SB-1:0] perm_state_out;
  logic          perm_done;
  logic [SB-1:0] perm_state_in;
  logic          busy;
  logic          absorb_done;
  logic          squeeze_ready;
  logic [SB-1:0] state_out;
  logic [15:0]   block_count;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  int delay = 2;
  int pend  = 0;
  int ctr   = 0;
  int abs_cnt = 0;
  int start_cnt = 0;
  int b0;
  int s0;

  keccak_absorb_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .state_clear    (state_clear),
    .block_valid    (block_valid),
    .block_in       (block_in),
    .last_block     (last_block),
    .perm_start     (perm_start),
    .perm_state_out (perm_state_out),
    .perm_done      (perm_done),
    .perm_state_in  (perm_state_in),
    .busy           (busy),
    .absorb_done    (absorb_done),
    .squeeze_ready  (squeeze_ready),
    .state_out      (state_out),
    .block_count    (block_count),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Permutation model: mode 0 identity, 1 invert, 2 never answers.
  initial begin
    perm_done = 1'b0;
    perm_state_in = '0;
    forever begin
      @(posedge clk);
      #1;
      perm_done = 1'b0;
      if (pend != 0) begin
        if (ctr <= 1) begin
          perm_done = 1'b1;
          perm_state_in = (mode == 1) ? ~perm_state_out : perm_state_out;
          pend = 0;
        end else begin
          ctr--;
        end
      end else if (perm_start && mode != 2) begin
        pend = 1;
        ctr = delay;
      end
    end
  end

  // Pulse counters.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (absorb_done) abs_cnt++;
      if (perm_start) start_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [SB-1:0] obs,
                     input logic [SB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h..%h want %h..%h", tag,
             obs[SB-1:SB-64], obs[63:0], exp[SB-1:SB-64], exp[63:0]);
    end
  endtask

  task automatic wait_absorb(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (absorb_done) seen = 1'b1;
    end
    chk({tag, "_absorb"}, SB'(seen), SB'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    block_valid = 1'b0;
    state_clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_block(input logic [RB-1:0] d, input logic lst,
                          input logic clr, input string tag);
    block_in = d;
    last_block = lst;
    state_clear = clr;
    block_valid = 1'b1;
    @(negedge clk);
    state_clear = 1'b0;
    wait_absorb(tag);
    block_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    state_clear = 1'b0;
    block_valid = 1'b0;
    last_block = 1'b0;
    block_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", SB'(busy), SB'(0));
    chk("rst_state", state_out, '0);
    chk("rst_cnt", SB'(block_count), SB'(0));
    chk("rst_flags", SB'({squeeze_ready, timeout_err, perm_start, absorb_done}), SB'(0));

    // All-ones last block, inverting permutation
    mode = 1;
    delay = 5;
    b0 = abs_cnt;
    s0 = start_cnt;
    block_in = '1;
    last_block = 1'b1;
    block_valid = 1'b1;
    @(negedge clk);
    chk("t1_start_n1", SB'(perm_start), SB'(0));
    @(negedge clk);
    chk("t1_start_n2", SB'(perm_start), SB'(1));
    chk("t1_pso", perm_state_out, {512'b0, {RB{1'b1}}});
    wait_absorb("t1");
    block_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_state", state_out, {{512{1'b1}}, {RB{1'b0}}});
    chk("t1_cnt", SB'(block_count), SB'(1));
    chk("t1_sq", SB'(squeeze_ready), SB'(1));
    chk("t1_abs_once", SB'(abs_cnt - b0), SB'(1));

    // Two blocks, identity permutation
    do_reset();
    mode = 0;
    delay = 2;
    do_block(RB'(1), 1'b0, 1'b0, "t2a");
    do_block(RB'(2), 1'b0, 1'b0, "t2b");
    chk("t2_state", state_out, SB'(3));
    chk("t2_cnt", SB'(block_count), SB'(2));
    chk("t2_sq", SB'(squeeze_ready), SB'(0));

    // Level held high does not retrigger
    do_reset();
    s0 = start_cnt;
    block_in = RB'(5);
    last_block = 1'b0;
    block_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3a_starts", SB'(start_cnt - s0), SB'(1));
    chk("t3a_cnt", SB'(block_count), SB'(1));
    block_valid = 1'b0;
    @(negedge clk);

    // Second edge during the wait is dropped
    do_reset();
    delay = 10;
    s0 = start_cnt;
    block_in = RB'(7);
    block_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3b_busy", SB'(busy), SB'(1));
    block_valid = 1'b0;
    @(negedge clk);
    block_valid = 1'b1;
    wait_absorb("t3b");
    repeat (5) @(negedge clk);
    chk("t3b_cnt", SB'(block_count), SB'(1));
    chk("t3b_starts", SB'(start_cnt - s0), SB'(1));
    chk("t3b_state", state_out, SB'(7));
    block_valid = 1'b0;
    @(negedge clk);

    // Permutation timeout
    do_reset();
    mode = 2;
    b0 = abs_cnt;
    block_in = {17{64'hA5A5_0F0F_1234_5678}};
    block_valid = 1'b1;
    repeat (257) @(negedge clk);
    chk("t4_busy_257", SB'(busy), SB'(1));
    chk("t4_terr_257", SB'(timeout_err), SB'(0));
    @(negedge clk);
    chk("t4_busy_258", SB'(busy), SB'(0));
    chk("t4_terr", SB'(timeout_err), SB'(1));
    chk("t4_cnt", SB'(block_count), SB'(0));
    chk("t4_noabs", SB'(abs_cnt - b0), SB'(0));
    chk("t4_state", state_out, {512'b0, {17{64'hA5A5_0F0F_1234_5678}}});
    block_valid = 1'b0;
    state_clear = 1'b1;
    @(negedge clk);
    state_clear = 1'b0;
    @(negedge clk);
    chk("t4_clr_terr", SB'(timeout_err), SB'(0));
    chk("t4_clr_state", state_out, '0);

    // Clear and edge together
    mode = 0;
    delay = 2;
    do_block({17{64'h00FF_00FF_00FF_00FF}}, 1'b0, 1'b0, "t5a");
    chk("t5_prior", state_out, {512'b0, {17{64'h00FF_00FF_00FF_00FF}}});
    do_block({17{64'h1111_2222_3333_4444}}, 1'b0, 1'b1, "t5b");
    chk("t5_state", state_out, {512'b0, {17{64'h1111_2222_3333_4444}}});
    chk("t5_cnt", SB'(block_count), SB'(1));

    // Asynchronous reset mid-wait
    mode = 1;
    delay = 20;
    block_in = RB'(9);
    last_block = 1'b1;
    block_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_busy", SB'(busy), SB'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_state", state_out, '0);
    chk("t6_rst_cnt", SB'(block_count), SB'(0));
    chk("t6_rst_flags", SB'({busy, perm_start, absorb_done, squeeze_ready}), SB'(0));
    @(negedge clk);
    reset = 1'b0;
    block_valid = 1'b0;
    b0 = abs_cnt;
    repeat (30) @(negedge clk);
    chk("t6_stale_abs", SB'(abs_cnt - b0), SB'(0));
    chk("t6_stale_state", state_out, '0);
    chk("t6_stale_busy", SB'(busy), SB'(0));
    mode = 0;
    delay = 2;
    do_block(RB'(9), 1'b1, 1'b0, "t6");
    chk("t6_state", state_out, SB'(9));
    chk("t6_cnt", SB'(block_count), SB'(1));
    chk("t6_sq", SB'(squeeze_ready), SB'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
